// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Sequential instruction fetch unit. It allows one outstanding memory request
//   at a time and buffers returned words in a small FIFO for the decode stage.
//   Branch/jump redirects flush the buffer and retarget the PC. A response
//   that is still in flight when a redirect arrives is drained and discarded.
//   A misaligned redirect target raises fetch_fault and halts fetching until
//   an aligned redirect arrives.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer depth (power of two, >= 2)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   imem_req, imem_addr           fetch request strobe / word-aligned address
//   imem_data, imem_rvalid        returned instruction word / its valid strobe
//   redirect_valid, redirect_pc   redirect strobe / new target
//   inst_valid, inst_ready        decode handshake
//   inst_data, inst_pc            head-of-buffer instruction and its address
//   fetch_fault                   misaligned redirect target seen
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_REQ,    // issue a request when the buffer has room
    S_WAIT,   // request outstanding, response will be kept
    S_DRAIN,  // request outstanding, response will be dropped
    S_HALT    // faulted, no requests until an aligned redirect
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc;
  logic [31:0]        fifo_data [FIFO_DEPTH];
  logic [31:0]        fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic fifo_has_room;
  logic in_flight;          // a response is owed by memory
  logic still_owed;         // a response will be owed after this cycle
  logic misaligned;
  logic push, pop;

  assign fifo_has_room = count < CNT_W'(FIFO_DEPTH);
  assign in_flight     = (state == S_WAIT) || (state == S_DRAIN);
  assign misaligned    = redirect_pc[1:0] != 2'b00;
  // A request issued this cycle, or one already in flight whose response has
  // not yet arrived, must be drained after a redirect.
  assign still_owed    = imem_req || (in_flight && !imem_rvalid);

  // A redirect discards any same-cycle push or pop.
  assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid && !rst;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so that every path assigns state_nxt (no latch).
    state_nxt = state;
    if (redirect_valid) begin
      if (still_owed)      state_nxt = S_DRAIN;
      else if (misaligned) state_nxt = S_HALT;
      else                 state_nxt = S_REQ;
    end else begin
      unique case (state)
        S_REQ:   if (imem_req)    state_nxt = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_nxt = S_REQ;
        // fetch_fault records whether the last redirect was misaligned.
        S_DRAIN: if (imem_rvalid) state_nxt = fetch_fault ? S_HALT : S_REQ;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Gated by rst so nothing is requested or presented while the
  // synchronous reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req   = !rst && (state == S_REQ) && fifo_has_room;
    imem_addr  = imem_req ? pc : 32'h0;
    inst_valid = !rst && (count != '0);
    inst_data  = fifo_data[head];
    inst_pc    = fifo_pc[head];
  end

  // ---------------------------------------------------------------------------
  // PC, fault flag and buffer bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      fetch_fault <= misaligned;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;   // wraps modulo 2^32
        tail <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: buffer storage has no reset; count alone decides which entries are
  // valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= imem_data;
      fifo_pc[tail]   <= pc;
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL be the instruction buffer depth (power of two, >=2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL be the fetch request strobe to instruction memory.
REQ-006 imem_addr  output  32  SHALL be the word-aligned byte address of the request.
REQ-007 imem_data  input  32  SHALL be the returned instruction word, sampled only when imem_rvalid=1.
REQ-008 imem_rvalid  input  1  SHALL mark imem_data valid, one or more cycles after the request.
REQ-009 redirect_valid  input  1  SHALL be the branch/jump redirect strobe.
REQ-010 redirect_pc  input  32  SHALL be the redirect target address.
REQ-011 inst_valid  output  1  SHALL flag a buffered instruction to decode.
REQ-012 inst_ready  input  1  SHALL be the decode accept signal.
REQ-013 inst_data  output  32  SHALL be the instruction at the buffer head.
REQ-014 inst_pc  output  32  SHALL be the address of inst_data.
REQ-015 fetch_fault  output  1  SHALL flag a misaligned redirect target.

Function
REQ-016 FSM states: REQ, WAIT, DRAIN, HALT; at most one outstanding memory request.
REQ-017 REQ: imem_req=1, imem_addr=pc only when FIFO count < FIFO_DEPTH; the request is accepted in that cycle; next state WAIT; otherwise imem_req=0 and the FSM stays in REQ.
REQ-018 WAIT: imem_req=0; on imem_rvalid, push {pc, imem_data}, pc<=pc+4, next state REQ.
REQ-019 PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-020 imem_addr SHALL be 0 whenever imem_req=0.
REQ-021 inst_valid = (count!=0); a pop occurs when inst_valid&&inst_ready; inst_data/inst_pc SHALL come from the head entry.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; overflow is impossible by the REQ gate of REQ-017.
REQ-023 Redirect has highest priority in every state: pc<=redirect_pc, FIFO flushed (count=0), so inst_valid=0 next cycle; any same-cycle pop or push is discarded.
REQ-024 Redirect in WAIT without imem_rvalid SHALL go to DRAIN; DRAIN waits for imem_rvalid, drops the data, then goes to REQ.
REQ-025 Redirect in WAIT with imem_rvalid in the same cycle SHALL drop the response and go to REQ.
REQ-026 Redirect during DRAIN SHALL update pc and remain in DRAIN.
REQ-027 redirect_pc[1:0]!=0: fetch_fault<=1, FIFO flushed; next state HALT, or DRAIN then HALT if a request is outstanding; HALT issues no requests.
REQ-028 An aligned redirect SHALL clear fetch_fault and leave HALT for REQ.
REQ-029 Latency: request at cycle N with imem_rvalid at N+1 SHALL give inst_valid=1 at N+2.

Reset
REQ-030 While rst=1: state=REQ, pc=RESET_PC, count=0, fetch_fault=0, imem_req=0, inst_valid=0, and any outstanding response is forgotten.
REQ-031 First cycle with rst=0: imem_req=1, imem_addr=RESET_PC.
REQ-032 imem_rvalid arriving in the first cycle after reset for a pre-reset request SHALL be ignored.

Verification
REQ-033 Reset, memory with 1-cycle latency, inst_ready=1 -> inst_pc sequence 0,4,8,... with inst_valid high every other cycle.
REQ-034 inst_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0, and no fetch beyond 0x8 until pops resume.
REQ-035 Redirect to 0x100 while in WAIT, response at +3 cycles -> response dropped, next imem_addr=0x100, and no stale inst_valid.
REQ-036 Redirect to 0x102 -> fetch_fault=1 and no imem_req; then redirect to 0x200 -> fault cleared and imem_addr=0x200.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x0.
REQ-038 rst asserted mid-WAIT, rvalid in the first cycle after release -> ignored, and fetch restarts at RESET_PC.
